// File: rtl/mini_risc_pkg.sv
// Types and defaults shared between the core and its data-memory responder.
package mini_risc_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, an asynchronous read port on the
// same index, and a synchronous clear of every word on reset.
module dmem_array #(
    parameter int DATA_W     = 32,
    parameter int DMEM_WORDS = 64,
    parameter int IDX_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES extra latency.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping them.
module dmem_responder
    import mini_risc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DMEM_WORDS  = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dmem_state_e            state;
    logic [WAIT_CNT_W-1:0]  cnt;
    logic                   lat_we;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DATA_W-1:0]      lat_wdata;

    logic                   accept;
    logic                   acc_en;
    logic                   acc_we;
    logic [ADDR_W-1:0]      acc_addr;
    logic [DATA_W-1:0]      acc_wdata;
    logic [IDX_W-1:0]       acc_idx;
    logic [DATA_W-1:0]      rd_data;
    logic                   oob;
    logic                   wr_en;

    assign accept = req_valid && req_ready;

    // With zero wait the access lands on the accept edge itself, so the live
    // request bypasses the latches while in IDLE.
    assign acc_we    = (state == IDLE) ? req_we    : lat_we;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_en    = (state == IDLE) ? (accept && (WAIT_CYCLES == 0))
                                       : ((state == WAIT) && (cnt == '0));
    assign acc_idx   = IDX_W'(acc_addr % ADDR_W'(DMEM_WORDS));

`ifdef DMEM_RANGE_CHECK_EN
    assign oob = (32'(acc_addr) >= $unsigned(DMEM_WORDS));
`else
    assign oob = 1'b0;
`endif

    assign wr_en = acc_en && acc_we && !oob;

    dmem_array #(
        .DATA_W     (DATA_W),
        .DMEM_WORDS (DMEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase

            // Response payload is captured once on entry to RESP and held there.
            if (acc_en) begin
                rsp_rdata <= (acc_we || oob) ? '0 : rd_data;
                rsp_err   <= oob;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (WAIT_CYCLES 0, 1, 3) driven from one clock.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [2:0][11:0]  req_addr;
    logic [2:0][31:0]  req_wdata, rsp_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    dmem_responder #(.WAIT_CYCLES(0)) u_wc0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]));

    dmem_responder #(.WAIT_CYCLES(1)) u_wc1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]));

    dmem_responder #(.WAIT_CYCLES(3)) u_wc3 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; rsp_ready is withheld for 'hold' cycles.
    task automatic txn(input int k, input string tag, input logic we,
                       input logic [11:0] addr, input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_addr[k]  = ~addr;
        req_wdata[k] = ~wd;
        lat = 1;
        while (!rsp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        if (!rsp_valid[k]) return;
        chk({tag, ".rd"}, rsp_rdata[k], exp_rd);
        chk({tag, ".err"}, 32'(rsp_err[k]), 32'(exp_err));
        chk({tag, ".busy"}, 32'(req_ready[k]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s.h%0d.vld", tag, i), 32'(rsp_valid[k]), 32'd1);
            chk($sformatf("%s.h%0d.rd", tag, i), rsp_rdata[k], exp_rd);
            chk($sformatf("%s.h%0d.err", tag, i), 32'(rsp_err[k]), 32'(exp_err));
            chk($sformatf("%s.h%0d.busy", tag, i), 32'(req_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk({tag, ".idle.rdy"}, 32'(req_ready[k]), 32'd1);
        chk({tag, ".idle.vld"}, 32'(rsp_valid[k]), 32'd0);
    endtask

    logic [11:0] b_addr [4];
    logic [31:0] b_exp  [4];
    int          acc_cyc[4];
    int          n_acc, n_rsp, seen;

    initial begin
        rst = 3'b111; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
        b_addr = '{12'd5, 12'd1, 12'd5, 12'd2};
        b_exp  = '{32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        acc_cyc = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        chk("rst.rdy", 32'(req_ready[1]), 32'd1);
        chk("rst.vld", 32'(rsp_valid[1]), 32'd0);
        chk("rst.rd",  rsp_rdata[1], 32'd0);
        chk("rst.err", 32'(rsp_err[1]), 32'd0);
        rst = 3'b000;

        // Zero-wait load straight after reset, then the range-check pair
        txn(0, "wc0.ld0", 1'b0, 12'd0, 32'h0, 0, 32'h0, 1'b0, 1);
`ifdef DMEM_RANGE_CHECK_EN
        txn(0, "wc0.st64", 1'b1, 12'd64, 32'h1234, 0, 32'h0, 1'b1, 1);
        txn(0, "wc0.ld0b", 1'b0, 12'd0, 32'h0, 0, 32'h0, 1'b0, 1);
`else
        txn(0, "wc0.st64", 1'b1, 12'd64, 32'h1234, 0, 32'h0, 1'b0, 1);
        txn(0, "wc0.ld0b", 1'b0, 12'd0, 32'h0, 0, 32'h1234, 1'b0, 1);
`endif

        txn(1, "wc1.st5", 1'b1, 12'd5, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2);
        txn(1, "wc1.ld5", 1'b0, 12'd5, 32'h0, 0, 32'hDEADBEEF, 1'b0, 2);
        txn(1, "wc1.hold", 1'b0, 12'd5, 32'h0, 5, 32'hDEADBEEF, 1'b0, 2);

        // Back-to-back loads with valid and rsp_ready held high
        n_acc = 0; n_rsp = 0;
        @(negedge clk);
        rsp_ready[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = b_addr[0]; req_valid[1] = 1'b1;
        for (int c = 0; c < 60 && n_rsp < 4; c++) begin
            if (rsp_valid[1]) begin
                chk($sformatf("b2b.rd%0d", n_rsp), rsp_rdata[1], b_exp[n_rsp]);
                n_rsp++;
            end
            if (req_ready[1] && req_valid[1]) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc_cnt;
                n_acc++;
            end else if (n_acc < 4) begin
                req_addr[1] = b_addr[n_acc];
            end else begin
                req_valid[1] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
        chk("b2b.nacc", 32'(n_acc), 32'd4);
        chk("b2b.nrsp", 32'(n_rsp), 32'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("b2b.gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

        // Top word, then an address one past the end
        txn(1, "wc1.st63", 1'b1, 12'd63, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 2);
        txn(1, "wc1.ld63", 1'b0, 12'd63, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 2);
`ifdef DMEM_RANGE_CHECK_EN
        txn(1, "wc1.ld127", 1'b0, 12'd127, 32'h0, 0, 32'h0, 1'b1, 2);
`else
        txn(1, "wc1.ld127", 1'b0, 12'd127, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 2);
`endif

        // Reset wipes storage
        @(negedge clk); rst[1] = 1'b1;
        @(negedge clk); rst[1] = 1'b0;
        txn(1, "wc1.clr5", 1'b0, 12'd5, 32'h0, 0, 32'h0, 1'b0, 2);

        // Reset in WAIT aborts a store
        @(negedge clk);
        chk("abort.rdy", 32'(req_ready[2]), 32'd1);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 12'd7; req_wdata[2] = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0; rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid[2]) seen = 1;
            @(negedge clk);
        end
        chk("abort.novld", 32'(seen), 32'd0);
        chk("abort.idle", 32'(req_ready[2]), 32'd1);
        txn(2, "wc3.ld7", 1'b0, 12'd7, 32'h0, 0, 32'h0, 1'b0, 4);
        txn(2, "wc3.st9", 1'b1, 12'd9, 32'h0BADF00D, 0, 32'h0, 1'b0, 4);
        txn(2, "wc3.ld9", 1'b0, 12'd9, 32'h0, 0, 32'h0BADF00D, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 12, request address width.
REQ-003 SHALL have parameter DMEM_WORDS, default 64, storage depth in words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, extra access latency in cycles.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-008 SHALL have port req_ready, output, 1, responder accepts a request.
REQ-009 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have port req_addr, input, ADDR_W, word address.
REQ-011 SHALL have port req_wdata, input, DATA_W, store data.
REQ-012 SHALL have port rsp_valid, output, 1, response available.
REQ-013 SHALL have port rsp_ready, input, 1, initiator accepts the response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, out-of-range access flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE, req_ready SHALL be 1; every other state SHALL drive 0.
REQ-018 A request SHALL be accepted on the cycle req_valid && req_ready; the responder SHALL latch req_we, req_addr and req_wdata on that cycle.
REQ-019 On accept with WAIT_CYCLES = 0, the next state SHALL be RESP; otherwise it SHALL be WAIT, with a down-counter loaded to WAIT_CYCLES-1.
REQ-020 WAIT SHALL decrement the counter each cycle and SHALL move to RESP on the cycle the counter is 0.
REQ-021 The memory access SHALL occur on entry to RESP. A store SHALL write the word; a load SHALL register the data into rsp_rdata.
REQ-022 Latency from the accept edge to the first rsp_valid = 1 cycle SHALL be WAIT_CYCLES+1 cycles.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_valid && rsp_ready.
REQ-024 On that rsp_valid && rsp_ready cycle the FSM SHALL return to IDLE; back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-025 A load SHALL return the value most recently stored to that address, including a store completed in the immediately preceding transaction.
REQ-026 req_wdata and req_addr changes outside the accept cycle SHALL have no effect.
REQ-027 An unknown FSM encoding SHALL recover to IDLE on the next clock.

Reset
REQ-028 rst SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and req_ready 1 on the following edge.
REQ-029 rst SHALL clear every storage word to 0.
REQ-030 rst asserted in WAIT or RESP SHALL abort the transaction: no write and no response.

Configuration
REQ-031 With macro DMEM_RANGE_CHECK_EN defined, req_addr >= DMEM_WORDS SHALL give rsp_err = 1 and rsp_rdata = 0, with no write, at the normal latency.
REQ-032 Without DMEM_RANGE_CHECK_EN, the address SHALL be req_addr modulo DMEM_WORDS and rsp_err SHALL be constant 0.

Structure
REQ-033 Package mini_risc_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP) and the DATA_W/ADDR_W defaults shared with the core.
REQ-034 Storage SHALL be a sub-module dmem_array containing only the synchronous write port, the read port and the reset clear; the FSM and handshake SHALL live in dmem_responder.

Verification
REQ-035 Scenario: WAIT_CYCLES=1; store addr 5 data 0xDEADBEEF, then load addr 5 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly 2 cycles after each accept.
REQ-036 Scenario: WAIT_CYCLES=0; load addr 0 right after reset -> rsp_rdata 0 one cycle after accept; req_ready 0 while rsp_valid 1.
REQ-037 Scenario: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_rdata/rsp_err stable and req_ready 0 throughout; return to IDLE 1 cycle after rsp_ready rises.
REQ-038 Scenario: with DMEM_RANGE_CHECK_EN, store addr 64 data 0x1234 -> rsp_err 1; load addr 0 -> 0. Without the macro, the same store followed by a load of addr 0 -> 0x1234.
REQ-039 Scenario: WAIT_CYCLES=3; rst pulsed during WAIT of a store to addr 7 data 0x55 -> no rsp_valid; a subsequent load of addr 7 -> 0.
REQ-040 Scenario: 4 back-to-back loads with req_valid and rsp_ready held high, WAIT_CYCLES=1 -> accepts spaced exactly 3 cycles apart.
